// File: rtl/board_pkg.sv
// Shared types and constants for the board memory access sequencer.
package board_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned NUM_LINES = 8;

  localparam logic [ADDR_W-1:0] NOP_ADDR = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    WRITE_X = 2'b10,
    WRITE_O = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    NO_WIN = 2'b00,
    TIE    = 2'b01,
    P2_WIN = 2'b10,
    P1_WIN = 2'b11
  } resultType;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    EVAL  = 3'd4
  } seq_state_t;

  // Cell-index triplets: 3 rows, 3 columns, 2 diagonals.
  localparam logic [ADDR_W-1:0] LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // All sequencer state that lives in the two-phase register.
  typedef struct packed {
    seq_state_t                  state;
    logic [ADDR_W-1:0]           cnt;
    logic [NUM_CELLS-1:0][1:0]   shadow;
    logic [1:0]                  result;
    logic                        game_done;
    logic                        result_valid;
  } seq_regs_t;

  localparam seq_regs_t SEQ_RESET = '{
    state:        CLEAR,
    cnt:          '0,
    shadow:       '0,
    result:       NO_WIN,
    game_done:    1'b0,
    result_valid: 1'b0
  };

endpackage

// File: rtl/board_access_sequencer_if.sv
// Move request, board memory port and result signals of the sequencer.
interface board_access_sequencer_if;
  import board_pkg::*;

  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_state;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_wdata;
  logic [1:0]        mem_rdata;
  logic              busy;
  logic              result_valid;
  logic [1:0]        result;
  logic              game_done;

  // Sequencer side: owns the memory port and reports results.
  modport master (
    input  wr_addr, wr_state, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata, busy, result_valid, result, game_done
  );

  // Environment side: game controller plus board memory.
  modport slave (
    output wr_addr, wr_state, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata, busy, result_valid, result, game_done
  );

endinterface

// File: rtl/board_access_sequencer_line_evaluator.sv
// Combinational win/tie evaluation of a 3x3 board snapshot.
module line_evaluator
  import board_pkg::*;
(
  input  logic [NUM_CELLS-1:0][1:0] shadow,
  output resultType                 result_c
);

  // O lines beat X lines; a full board with no line is a tie.
  always_comb begin
    logic o_line;
    logic x_line;
    logic full;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    o_line   = 1'b0;
    x_line   = 1'b0;
    full     = 1'b1;
    a        = EMPTY;
    b        = EMPTY;
    c        = EMPTY;
    result_c = NO_WIN;
    for (int i = 0; i < NUM_LINES; i++) begin
      a = shadow[LINE_TABLE[i][0]];
      b = shadow[LINE_TABLE[i][1]];
      c = shadow[LINE_TABLE[i][2]];
      if (a == b && b == c && a == WRITE_O) o_line = 1'b1;
      if (a == b && b == c && a == WRITE_X) x_line = 1'b1;
    end
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (shadow[ADDR_W'(k)] == EMPTY) full = 1'b0;
    end
    if (o_line)      result_c = P1_WIN;
    else if (x_line) result_c = P2_WIN;
    else if (full)   result_c = TIE;
    else             result_c = NO_WIN;
  end

endmodule

// File: rtl/board_access_sequencer.sv
// Arbitrates the single board memory port between move writes, the
// post-reset clear and the read-back scanner, and reports win/tie results.
module board_access_sequencer
  import board_pkg::*;
(
  input  logic                     ph1,
  input  logic                     ph2,
  input  logic                     reset,
  board_access_sequencer_if.master bus
);

  seq_regs_t q;
  seq_regs_t hold;
  seq_regs_t next_c;
  seq_regs_t reset_mux_c;
  resultType eval_c;
  logic      move_ok_c;

  line_evaluator u_line_evaluator (
    .shadow   (q.shadow),
    .result_c (eval_c)
  );

  // A move is legal on an in-range cell with a player mark, once the board is cleared and the game is open.
  always_comb begin
    move_ok_c = reset
              && (bus.wr_addr < ADDR_W'(NUM_CELLS))
              && (bus.wr_state == WRITE_O || bus.wr_state == WRITE_X)
              && (q.state != CLEAR)
              && !q.game_done;
  end

  // Memory port mux: clear writes, then accepted moves, then scanner reads.
  always_comb begin
    bus.mem_addr  = NOP_ADDR;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = EMPTY;
    bus.wr_ack    = 1'b0;
    if (reset) begin
      if (q.state == CLEAR) begin
        bus.mem_addr  = q.cnt;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = EMPTY;
      end else if (move_ok_c) begin
        bus.mem_addr  = bus.wr_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.wr_state;
        bus.wr_ack    = 1'b1;
      end else if (q.state == SCAN) begin
        bus.mem_addr = q.cnt;
      end
    end
  end

  // Status outputs straight from the register.
  always_comb begin
    bus.busy         = !reset || (q.state != IDLE);
    bus.result       = q.result;
    bus.game_done    = q.game_done;
    bus.result_valid = q.result_valid;
  end

  // Next-state logic; an accepted move always (re)starts the scan from cell 0.
  always_comb begin
    next_c              = q;
    next_c.result_valid = 1'b0;
    unique case (q.state)
      CLEAR: begin
        if (q.cnt == ADDR_W'(NUM_CELLS - 1)) begin
          next_c.state = IDLE;
          next_c.cnt   = '0;
        end else begin
          next_c.cnt = q.cnt + 4'd1;
        end
      end
      IDLE: begin
        next_c.cnt = '0;
      end
      SCAN: begin
        if (q.cnt != '0) next_c.shadow[q.cnt - 4'd1] = bus.mem_rdata;
        if (q.cnt == ADDR_W'(NUM_CELLS - 1)) begin
          next_c.state = DRAIN;
        end else begin
          next_c.cnt = q.cnt + 4'd1;
        end
      end
      DRAIN: begin
        next_c.shadow[ADDR_W'(NUM_CELLS - 1)] = bus.mem_rdata;
        next_c.state                          = EVAL;
      end
      EVAL: begin
        next_c.result       = eval_c;
        next_c.game_done    = q.game_done || (eval_c != NO_WIN);
        next_c.result_valid = 1'b1;
        next_c.state        = IDLE;
      end
      default: begin
        next_c = SEQ_RESET;
      end
    endcase
    if (move_ok_c) begin
      next_c.state        = SCAN;
      next_c.cnt          = '0;
      next_c.result       = q.result;
      next_c.game_done    = q.game_done;
      next_c.result_valid = 1'b0;
    end
  end

  // Synchronous reset as a mux in front of the flop.
  always_comb begin
    reset_mux_c = reset ? next_c : SEQ_RESET;
  end

  // Master stage captures the next state on phase 2.
  always_ff @(posedge ph2) begin
    hold <= reset_mux_c;
  end

  // Slave stage presents it from phase 1 of the following cycle.
  always_ff @(posedge ph1) begin
    q <= hold;
  end

endmodule

// File: doc/board_access_sequencer.md
Name: board_access_sequencer

Overview:
- Owns the single port of the 9-cell board memory and arbitrates between three users: the game controller's move writes, a post-reset board clear, and a win/tie scanner.
- After every accepted move it reads all 9 cells back and evaluates the 8 lines.
- It drives game_done and result to the game controller.
- It sits between the game controller and the board memory.

Parameters:
- NUM_CELLS, 9, number of board cells (addresses 0..NUM_CELLS-1).
- ADDR_W, 4, memory address width.
- NOP_ADDR, 4'b1111, address value meaning "no request / no write".

Ports:
- ph1  in  1  two-phase clock, phase 1
- ph2  in  1  two-phase clock, phase 2
- reset  in  1  synchronous, active-low
- wr_addr  in  4  move request cell; NOP_ADDR = no request
- wr_state  in  2  cellStateType to write (WRITE_O=11, WRITE_X=10)
- wr_ack  out  1  move accepted and written this cycle
- mem_addr  out  4  board memory address (NOP_ADDR when idle)
- mem_we  out  1  board memory write enable
- mem_wdata  out  2  board memory write data
- mem_rdata  in  2  board memory read data, valid one cycle after address
- busy  out  1  clear or scan in progress
- result_valid  out  1  one-cycle pulse, result updated
- result  out  2  11 player1 (O) win, 10 player2 (X) win, 01 tie, 00 no win
- game_done  out  1  sticky: a win or tie has been detected

Behaviour:
- Reset (reset=0, sampled on clock):
  - State CLEAR, cell counter 0.
  - result=00, result_valid=0, game_done=0, wr_ack=0, mem_we=0, mem_addr=NOP_ADDR, busy=1.
  - Reset asserted mid-scan or mid-clear aborts immediately.
- States:
  - CLEAR: writes EMPTY to cells 0..8, one per cycle, starting in the first cycle after reset release. mem_we=1, mem_wdata=00. Moves to IDLE after cell 8.
  - IDLE: busy=0, mem_addr=NOP_ADDR.
  - SCAN: issues read addresses 0..8 on consecutive cycles and captures mem_rdata of address k into shadow[k] one cycle later.
  - DRAIN: captures cell 8.
  - EVAL: evaluates lines from the shadow and registers result, game_done and result_valid. result_valid is high in the cycle after EVAL; the block then returns to IDLE.
- Move acceptance: a move is valid when wr_addr < NUM_CELLS, wr_state is WRITE_O or WRITE_X, state is not CLEAR, and game_done=0.
  - A valid move gets mem_addr=wr_addr, mem_we=1, mem_wdata=wr_state and wr_ack=1, all in the same cycle (combinational).
  - Invalid or NOP requests: wr_ack=0, mem_we=0, no state change.
- Arbitration: an accepted move has priority over scanner reads.
  - A move accepted in IDLE, SCAN, DRAIN or EVAL starts or restarts the scan from cell 0 in the next cycle.
  - A restart discards the partial shadow and any pending result, so no result_valid pulse occurs.
- Latency: move accepted in cycle W with no further moves:
  - SCAN runs cycles W+1..W+9.
  - DRAIN at W+10, EVAL at W+11.
  - result_valid=1 in W+12.
- Evaluation:
  - Lines are 3 rows, 3 columns and 2 diagonals.
  - A line is won when all 3 cells are equal and non-EMPTY.
  - An O line gives 11 and has priority if both players have lines; otherwise an X line gives 10.
  - No line with all 9 cells non-EMPTY gives 01; otherwise 00.
  - game_done is set when result is 11, 10 or 01, and holds until reset.
- Holding rules: result holds between evaluations. mem_rdata is ignored outside SCAN and DRAIN.

Decomposition:
- Package board_pkg holds:
  - cellStateType (EMPTY=00, WRITE_O=11, WRITE_X=10)
  - resultType (NO_WIN=00, TIE=01, P2_WIN=10, P1_WIN=11)
  - the sequencer state enum {CLEAR, IDLE, SCAN, DRAIN, EVAL}
  - the 8-entry line table of cell-index triplets
  - NOP_ADDR
- One combinational sub-module, line_evaluator: takes the 9x2-bit shadow and produces resultType.
- The state register uses the existing flop and mux2 reset style.

Test Plan:
- Reset release -> mem_we=1 with mem_addr 0..8 and mem_wdata=00 on 9 consecutive cycles, busy=1 throughout; busy=0 afterwards; wr_ack=0 for a move issued during clear.
- Moves O@0, X@3, O@1, X@4, O@2, each issued after the previous result_valid -> each result_valid arrives 12 cycles after its wr_ack; result=00 for the first four moves, then result=11 and game_done=1.
- X@4 issued at cycle W+5 of a scan started by O@0 -> no pulse at W+12; the scan restarts at W+6, result_valid arrives at W+5+12, and mem_addr shows 4 with mem_we=1 in cycle W+5.
- Full board O X O / O X X / X O O (no line) -> result=01, game_done=1; a subsequent move with wr_addr=0 gets wr_ack=0 and mem_we=0.
- wr_addr=9, wr_addr=15 and wr_state=00 requests -> wr_ack=0, mem_we=0, no scan started.
- Reset asserted during SCAN -> next cycle state is CLEAR, game_done=0, result=00, no result_valid; a fresh clear sequence follows.
